// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with per-owner hold timeout and a one-cycle turnaround between owners.
// Optional macro ARB_ROUND_ROBIN_EN: alternate winners on simultaneous requests (default: master 0 wins).
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic req_m0,
  input  logic req_m1,
  input  logic done_m0,
  input  logic done_m1,
  output logic grant_m0,
  output logic grant_m1,
  output logic busy_m0,
  output logic busy_m1,
  output logic bus_sel,
  output logic timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_M0  = 2'd1,
    ST_OWN_M1  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic             w_limit;
  logic             w_timeout_nxt;
  logic             w_bus_sel_nxt;
  logic             w_pick_m1;

  assign w_limit = (r_hold_cnt == LP_LIMIT);

`ifdef ARB_ROUND_ROBIN_EN
  // r_last_m1 remembers the most recently granted master; reset value makes master 0 next.
  logic r_last_m1;

  // Round-robin winner: contention goes to the master not granted last.
  always_comb begin
    if (req_m0 && req_m1) begin
      w_pick_m1 = ~r_last_m1;
    end else begin
      w_pick_m1 = req_m1;
    end
  end

  // Update the pointer whenever a new owner is chosen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_m1 <= 1'b1;
    end else if ((r_state == ST_IDLE) && (req_m0 || req_m1)) begin
      r_last_m1 <= w_pick_m1;
    end else begin
      r_last_m1 <= r_last_m1;
    end
  end
`else
  assign w_pick_m1 = req_m1 & ~req_m0;
`endif

  // Next-state, hold counter and timeout decision.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = {CNT_W{1'b0}};
    w_timeout_nxt  = 1'b0;
    w_bus_sel_nxt  = bus_sel;
    case (r_state)
      ST_IDLE: begin
        if (req_m0 || req_m1) begin
          w_state_nxt   = w_pick_m1 ? ST_OWN_M1 : ST_OWN_M0;
          w_bus_sel_nxt = w_pick_m1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OWN_M0: begin
        // A normal completion in the limit cycle wins over the forced revocation.
        if (done_m0 || !req_m0) begin
          w_state_nxt = ST_RELEASE;
        end else if (w_limit) begin
          w_state_nxt   = ST_RELEASE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_OWN_M1: begin
        if (done_m1 || !req_m1) begin
          w_state_nxt = ST_RELEASE;
        end else if (w_limit) begin
          w_state_nxt   = ST_RELEASE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter and outputs all registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= {CNT_W{1'b0}};
      grant_m0   <= 1'b0;
      grant_m1   <= 1'b0;
      busy_m0    <= 1'b0;
      busy_m1    <= 1'b0;
      bus_sel    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      grant_m0   <= (w_state_nxt == ST_OWN_M0);
      grant_m1   <= (w_state_nxt == ST_OWN_M1);
      busy_m0    <= (w_state_nxt == ST_OWN_M1) || (w_state_nxt == ST_RELEASE);
      busy_m1    <= (w_state_nxt == ST_OWN_M0) || (w_state_nxt == ST_RELEASE);
      bus_sel    <= w_bus_sel_nxt;
      timeout    <= w_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written timeout/contention
// sequences, and randomized traffic against an ownership-level reference model.
module tb_bus_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_m0 = 1'b0, req_m1 = 1'b0, done_m0 = 1'b0, done_m1 = 1'b0;
  logic grant_m0, grant_m1, busy_m0, busy_m1, bus_sel, timeout;

  int n_vec = 0;
  int n_bad = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_m0(req_m0), .req_m1(req_m1), .done_m0(done_m0), .done_m1(done_m1),
    .grant_m0(grant_m0), .grant_m1(grant_m1), .busy_m0(busy_m0), .busy_m1(busy_m1),
    .bus_sel(bus_sel), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, how many cycles it has held it, and whether
  // the bus is in its turnaround cycle.
  int   m_owner = -1;
  int   m_n     = 0;
  logic m_turn  = 1'b0;
  logic m_sel   = 1'b0;
  logic m_to    = 1'b0;
  logic m_last  = 1'b1;

  function automatic int winner(input logic q0, input logic q1, input logic last);
`ifdef ARB_ROUND_ROBIN_EN
    if (q0 && q1) return last ? 0 : 1;
`endif
    return q0 ? 0 : 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_owner <= -1; m_n <= 0; m_turn <= 1'b0; m_sel <= 1'b0; m_to <= 1'b0; m_last <= 1'b1;
    end else if (m_turn) begin
      m_turn <= 1'b0; m_to <= 1'b0;
    end else if (m_owner >= 0) begin
      if ((m_owner == 0 ? (done_m0 || !req_m0) : (done_m1 || !req_m1))) begin
        m_owner <= -1; m_turn <= 1'b1; m_to <= 1'b0;
      end else if (m_n == TO) begin
        m_owner <= -1; m_turn <= 1'b1; m_to <= 1'b1;
      end else begin
        m_n <= m_n + 1;
      end
    end else if (req_m0 || req_m1) begin
      m_owner <= winner(req_m0, req_m1, m_last);
      m_sel   <= (winner(req_m0, req_m1, m_last) == 1);
      m_last  <= (winner(req_m0, req_m1, m_last) == 1);
      m_n     <= 1;
      m_to    <= 1'b0;
    end else begin
      m_to <= 1'b0;
    end
  end

  function automatic logic [5:0] model_exp();
    return {m_owner == 0, m_owner == 1, m_turn || m_owner == 1, m_turn || m_owner == 0, m_sel, m_to};
  endfunction

  function automatic logic [5:0] own_exp(input int o);
    return {o == 0, o == 1, o == 1, o == 0, o == 1, 1'b0};
  endfunction

  task automatic step(input logic r, input logic q0, input logic q1, input logic d0, input logic d1);
    reset = r; req_m0 = q0; req_m1 = q1; done_m0 = d0; done_m1 = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {grant_m0, grant_m1, busy_m0, busy_m1, bus_sel, timeout};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got g0g1b0b1sel_to=%b, expected %b", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0] in;   // {reset, req_m0, req_m1, done_m0, done_m1}
    logic [5:0] exp;  // {grant_m0, grant_m1, busy_m0, busy_m1, bus_sel, timeout}
  } vec_t;

  vec_t tbl[15];
  int   own;
  int   rate;
  logic q0, q1;

  initial begin
    tbl[0]  = {5'b10000, 6'b000000};  // reset state
    tbl[1]  = {5'b01000, 6'b100100};  // m0 granted one cycle after request
    tbl[2]  = {5'b01001, 6'b100100};  // done from non-owner ignored
    tbl[3]  = {5'b01110, 6'b001100};  // done_m0 -> turnaround
    tbl[4]  = {5'b00100, 6'b000000};  // turnaround -> idle even with a request
    tbl[5]  = {5'b00100, 6'b011010};  // m1 granted, bus_sel=1
    tbl[6]  = {5'b00000, 6'b001110};  // req drop releases
    tbl[7]  = {5'b00000, 6'b000010};  // idle keeps bus_sel
    tbl[8]  = {5'b00000, 6'b000010};
    tbl[9]  = {5'b01100, 6'b100100};  // simultaneous -> m0
    tbl[10] = {5'b11000, 6'b000000};  // reset mid-ownership drops at once
    tbl[11] = {5'b00100, 6'b011010};
    tbl[12] = {5'b00101, 6'b001110};
    tbl[13] = {5'b01000, 6'b000010};
    tbl[14] = {5'b01000, 6'b100100};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Timeout: 16 granted cycles, timeout pulse in turnaround, idle, then re-grant.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_reset", 6'b000000);
    for (int i = 0; i < TO; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("to_hold[%0d]", i), own_exp(1));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("to_pulse", 6'b001111);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("to_idle", 6'b000010);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("to_regrant", own_exp(1));

    // done in the limit cycle: plain release, no timeout pulse.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TO; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("lim_hold[%0d]", i), own_exp(1));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("lim_done_no_to", 6'b001110);

    // Continuous contention, each owner signals done on its fifth granted cycle.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      own = r % 2;
`else
      own = 0;
`endif
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        if (k == 0 || k == 4) check($sformatf("cont[%0d].own%0d", r, k), own_exp(own));
      end
      step(1'b0, 1'b1, 1'b1, own == 0, own == 1);
      check($sformatf("cont[%0d].rel", r), {4'b0011, own == 1, 1'b0});
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check($sformatf("cont[%0d].idle", r), {4'b0000, own == 1, 1'b0});
    end

    // Randomized traffic against the reference model.
    q0 = 1'b0; q1 = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rate = (c < 2000) ? 6 : 40;
      if ($urandom_range(7) == 0) q0 = ~q0;
      if ($urandom_range(7) == 0) q1 = ~q1;
      step($urandom_range(299) == 0, q0, q1,
           $urandom_range(rate - 1) == 0, $urandom_range(rate - 1) == 0);
      check($sformatf("rand[%0d]", c), model_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
